// File: rtl/rx_rr_arbiter_pkg.sv
// Shared constants for the router rx-side arbitration: flit geometry,
// direction indices and the "no grant yet" marker.
package rx_rr_arbiter_pkg;
  localparam int DIRECTIONS = 5;
  localparam int HDR_SZ     = 4;
  localparam int PL_SZ      = 16;
  localparam int ADDR_SZ    = 4;
  localparam int ITEM_SZ    = HDR_SZ + PL_SZ + ADDR_SZ;

  localparam logic [2:0] DIR_N      = 3'd0;
  localparam logic [2:0] DIR_E      = 3'd1;
  localparam logic [2:0] DIR_S      = 3'd2;
  localparam logic [2:0] DIR_W      = 3'd3;
  localparam logic [2:0] DIR_L      = 3'd4;
  localparam logic [2:0] GRANT_NONE = 3'd7;
endpackage

// File: rtl/rx_rr_arbiter_pick5.sv
// Five-way rotate-priority encoder: first set req at or after ptr, mod 5.
// Also suitable for tx-side output arbitration.
module rr_pick5
  import rx_rr_arbiter_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx
);
  logic [2:0] base;
  logic [2:0] idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = DIR_N;
    idx       = DIR_N;
    // Out-of-range pointer behaves as 0.
    base      = (ptr > DIR_L) ? DIR_N : ptr;
    // Walk from furthest to nearest so the nearest hit wins.
    for (int i = 4; i >= 0; i--) begin
      idx = 3'((int'(base) + i) % 5);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end
endmodule

// File: rtl/rx_rr_arbiter.sv
// Round-robin arbiter from the five rx deserialisers into the shared router
// input FIFO, with a one-entry registered output stage.
module rx_rr_arbiter
  import rx_rr_arbiter_pkg::*;
#(
  parameter int ITEM_W = ITEM_SZ,
  parameter int DIRS   = DIRECTIONS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DIRS-1:0]        valid,
  input  logic [DIRS*ITEM_W-1:0] items,
  output logic [DIRS-1:0]        item_read,
  input  logic [DIRS-1:0]        port_en,
  input  logic                   full,
  output logic                   write,
  output logic [ITEM_W-1:0]      item_out,
  output logic [2:0]             last_grant
);
  logic [2:0]        ptr;
  logic              out_valid;
  logic [ITEM_W-1:0] out_item;
  logic [DIRS-1:0]   req;
  logic              accept;
  logic              gnt_valid;
  logic [2:0]        gnt_idx;
  logic              grant;
  logic [ITEM_W-1:0] item_arr [DIRS];

  for (genvar k = 0; k < DIRS; k++) begin : g_split
    assign item_arr[k] = items[k*ITEM_W +: ITEM_W];
  end

  assign req    = valid & port_en;
  assign accept = !out_valid || !full;

  rr_pick5 u_pick (
    .req       (req),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Reset gates the strobes so nothing is popped or written while resetting.
  assign grant     = gnt_valid && accept && !reset;
  assign item_read = grant ? (DIRS'(1) << gnt_idx) : '0;
  assign write     = out_valid && !full && !reset;
  assign item_out  = out_item;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= DIR_N;
      out_valid  <= 1'b0;
      out_item   <= '0;
      last_grant <= GRANT_NONE;
    end else if (grant) begin
      out_item   <= item_arr[gnt_idx];
      out_valid  <= 1'b1;
      ptr        <= (gnt_idx == DIR_L) ? DIR_N : gnt_idx + 3'd1;
      last_grant <= gnt_idx;
    end else if (write) begin
      out_valid  <= 1'b0;
    end
  end
endmodule
